// File: rtl/uart_rx_peripheral_if.sv
// uart_rx_peripheral_if: FIFO read port and sticky status of the UART receiver
interface uart_rx_peripheral_if;
  logic       i_uart_rx_rd;
  logic       i_uart_rx_err_clr;
  logic [7:0] o_uart_rx_pdata;
  logic       o_uart_rx_valid;
  logic       o_uart_fifo_full;
  logic       o_uart_rx_parity_err;
  logic       o_uart_rx_frame_err;
  logic       o_uart_rx_overrun;
  modport master (
    output i_uart_rx_rd, i_uart_rx_err_clr,
    input  o_uart_rx_pdata, o_uart_rx_valid, o_uart_fifo_full,
           o_uart_rx_parity_err, o_uart_rx_frame_err, o_uart_rx_overrun
  );
  modport slave (
    input  i_uart_rx_rd, i_uart_rx_err_clr,
    output o_uart_rx_pdata, o_uart_rx_valid, o_uart_fifo_full,
           o_uart_rx_parity_err, o_uart_rx_frame_err, o_uart_rx_overrun
  );
endinterface

// File: rtl/uart_rx_peripheral.sv
// uart_rx_peripheral: 16x oversampling 8N1/8E1/8O1 receiver feeding a FWFT FIFO with sticky error flags
module uart_rx_peripheral #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int PAR_EN     = 1,
  parameter int PAR_TYPE   = 0,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV        = CLK_FREQ / (BAUD_RATE * 16)
) (
  input logic             i_uart_clk,
  input logic             i_uart_rst_n,
  input logic             i_uart_rx_sdata,
  uart_rx_peripheral_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int DW = DIV > 1 ? $clog2(DIV) : 1;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t state, nxt;
  logic [1:0] sync;
  logic rx_s, armed, tick, centre, go, push, set_pe, set_fe, par_bad;
  logic pe_r, fe_r, ov_r;
  logic [DW-1:0] div_cnt;
  logic [3:0] smp_cnt;
  logic [2:0] bit_cnt;
  logic [7:0] shreg;
  logic [7:0] mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic empty, full, do_pop, do_push;
  assign rx_s   = sync[1];
  assign tick   = div_cnt == DW'(DIV - 1);
  assign centre = tick && smp_cnt == 4'd7;
  always_ff @(posedge i_uart_clk or negedge i_uart_rst_n)
    if (!i_uart_rst_n) sync <= 2'b11;
    else sync <= {sync[0], i_uart_rx_sdata};
  always_ff @(posedge i_uart_clk or negedge i_uart_rst_n)
    if (!i_uart_rst_n) begin
      div_cnt <= '0;
      smp_cnt <= '0;
    end else if (go) begin
      div_cnt <= '0;
      smp_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
      smp_cnt <= smp_cnt + 4'd1;
    end else div_cnt <= div_cnt + DW'(1);
  always_ff @(posedge i_uart_clk or negedge i_uart_rst_n)
    if (!i_uart_rst_n) state <= IDLE;
    else state <= nxt;
  // leaving STOP early (at its centre) tolerates baud mismatch between ends
  always_comb begin
    nxt    = state;
    go     = 1'b0;
    push   = 1'b0;
    set_pe = 1'b0;
    set_fe = 1'b0;
    case (state)
      IDLE:   if (armed && !rx_s) begin
                nxt = START;
                go  = 1'b1;
              end
      START:  if (centre) nxt = rx_s ? IDLE : DATA;
      DATA:   if (centre && bit_cnt == 3'd7) nxt = PAR_EN != 0 ? PARITY : STOP;
      PARITY: if (centre) nxt = STOP;
      STOP:   if (centre) begin
                nxt    = IDLE;
                set_fe = !rx_s;
                set_pe = rx_s && par_bad;
                push   = rx_s && !par_bad;
              end
      default: nxt = IDLE;
    endcase
  end
  // armed is dropped on every entry to IDLE so a stuck-low line cannot retrigger
  always_ff @(posedge i_uart_clk or negedge i_uart_rst_n)
    if (!i_uart_rst_n) begin
      armed   <= 1'b0;
      bit_cnt <= '0;
      shreg   <= '0;
      par_bad <= 1'b0;
    end else begin
      armed <= state == IDLE && nxt == IDLE && (armed || rx_s);
      if (go) begin
        bit_cnt <= '0;
        par_bad <= 1'b0;
      end
      if (state == DATA && centre) begin
        shreg   <= {rx_s, shreg[7:1]};
        bit_cnt <= bit_cnt + 3'd1;
      end
      if (state == PARITY && centre) par_bad <= (^shreg ^ rx_s) != PAR_TYPE[0];
    end
  assign empty   = wr_ptr == rd_ptr;
  assign full    = wr_ptr == {~rd_ptr[AW], rd_ptr[AW-1:0]};
  assign do_pop  = bus.i_uart_rx_rd && !empty;
  assign do_push = push && (!full || do_pop);
  always_ff @(posedge i_uart_clk or negedge i_uart_rst_n)
    if (!i_uart_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= shreg;
        wr_ptr <= wr_ptr + (AW+1)'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  always_ff @(posedge i_uart_clk or negedge i_uart_rst_n)
    if (!i_uart_rst_n) begin
      pe_r <= 1'b0;
      fe_r <= 1'b0;
      ov_r <= 1'b0;
    end else begin
      pe_r <= set_pe | (pe_r & ~bus.i_uart_rx_err_clr);
      fe_r <= set_fe | (fe_r & ~bus.i_uart_rx_err_clr);
      ov_r <= (push & full & ~do_pop) | (ov_r & ~bus.i_uart_rx_err_clr);
    end
  assign bus.o_uart_rx_pdata      = mem[rd_ptr[AW-1:0]];
  assign bus.o_uart_rx_valid      = !empty;
  assign bus.o_uart_fifo_full     = full;
  assign bus.o_uart_rx_parity_err = pe_r;
  assign bus.o_uart_rx_frame_err  = fe_r;
  assign bus.o_uart_rx_overrun    = ov_r;
endmodule

// File: tb/tb_uart_rx_peripheral.sv
// tb_uart_rx_peripheral: vector table, corner sequences and a randomized queue-model run for the UART receiver
module tb_uart_rx_peripheral;
  localparam int BIT = 64;
  logic clk = 1'b0, rst_n = 1'b0, sd = 1'b1;
  int n_chk = 0, n_fail = 0, cyc, lat1, lat0;
  logic pv1, pv0;
  always #5 clk = ~clk;
  uart_rx_peripheral_if b1 (), b0 ();
  uart_rx_peripheral #(.CLK_FREQ(7_372_800), .BAUD_RATE(115200), .PAR_EN(1), .PAR_TYPE(0), .FIFO_DEPTH(16))
    dut1 (.i_uart_clk(clk), .i_uart_rst_n(rst_n), .i_uart_rx_sdata(sd), .bus(b1));
  uart_rx_peripheral #(.CLK_FREQ(7_372_800), .BAUD_RATE(115200), .PAR_EN(0), .PAR_TYPE(0), .FIFO_DEPTH(16))
    dut0 (.i_uart_clk(clk), .i_uart_rst_n(rst_n), .i_uart_rx_sdata(sd), .bus(b0));
  typedef struct {logic [7:0] d; logic pbad; logic stop; logic ev; logic epe; logic efe;} vec_t;
  vec_t tbl[7];
  logic [7:0] q[$];
  logic mpe, mfe, mov;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask
  task automatic line_bit(input logic b);
    sd = b;
    repeat (BIT) begin
      @(negedge clk);
      cyc++;
      if (b1.o_uart_rx_valid && !pv1 && lat1 < 0) lat1 = cyc;
      if (b0.o_uart_rx_valid && !pv0 && lat0 < 0) lat0 = cyc;
      pv1 = b1.o_uart_rx_valid;
      pv0 = b0.o_uart_rx_valid;
    end
  endtask
  task automatic send(input logic [7:0] d, input logic pbad, input logic stop, input logic par);
    cyc = 0; lat1 = -1; lat0 = -1;
    pv1 = b1.o_uart_rx_valid;
    pv0 = b0.o_uart_rx_valid;
    line_bit(1'b0);
    for (int i = 0; i < 8; i++) line_bit(d[i]);
    if (par) line_bit(^d ^ pbad);
    line_bit(stop);
  endtask
  task automatic idle(input int n);
    sd = 1'b1;
    repeat (n) @(negedge clk);
  endtask
  task automatic pop1();
    b1.i_uart_rx_rd = 1'b1;
    @(negedge clk);
    b1.i_uart_rx_rd = 1'b0;
  endtask
  task automatic clr1();
    b1.i_uart_rx_err_clr = 1'b1;
    @(negedge clk);
    b1.i_uart_rx_err_clr = 1'b0;
  endtask
  task automatic chk_model();
    chk("rnd valid", b1.o_uart_rx_valid, q.size() != 0);
    chk("rnd full", b1.o_uart_fifo_full, q.size() == 16);
    chk("rnd perr", b1.o_uart_rx_parity_err, mpe);
    chk("rnd ferr", b1.o_uart_rx_frame_err, mfe);
    chk("rnd ovr", b1.o_uart_rx_overrun, mov);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  initial begin
    b1.i_uart_rx_rd = 0; b1.i_uart_rx_err_clr = 0;
    b0.i_uart_rx_rd = 0; b0.i_uart_rx_err_clr = 0;
    tbl[0] = '{8'hA5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{8'h01, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[4] = '{8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[5] = '{8'h80, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[6] = '{8'h7E, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    repeat (4) @(negedge clk);
    chk("rst valid", b1.o_uart_rx_valid, 0);
    chk("rst pdata", b1.o_uart_rx_pdata, 0);
    chk("rst full", b1.o_uart_fifo_full, 0);
    chk("rst perr", b1.o_uart_rx_parity_err, 0);
    chk("rst ferr", b1.o_uart_rx_frame_err, 0);
    chk("rst ovr", b1.o_uart_rx_overrun, 0);
    rst_n = 1'b1;
    idle(20);
    for (int i = 0; i < 7; i++) begin
      send(tbl[i].d, tbl[i].pbad, tbl[i].stop, 1'b1);
      idle(16);
      chk("tbl valid", b1.o_uart_rx_valid, tbl[i].ev);
      chk("tbl perr", b1.o_uart_rx_parity_err, tbl[i].epe);
      chk("tbl ferr", b1.o_uart_rx_frame_err, tbl[i].efe);
      if (tbl[i].ev) begin
        chk("tbl pdata", b1.o_uart_rx_pdata, tbl[i].d);
        chk("tbl latency", lat1 >= 666 && lat1 <= 682, 1);
        pop1();
        chk("tbl pop", b1.o_uart_rx_valid, 0);
      end
      clr1();
      chk("tbl clr", {b1.o_uart_rx_parity_err, b1.o_uart_rx_frame_err}, 0);
    end
    send(8'h3C, 1'b0, 1'b0, 1'b1);
    sd = 1'b0;
    repeat (200) @(negedge clk);
    chk("low valid", b1.o_uart_rx_valid, 0);
    chk("low ferr", b1.o_uart_rx_frame_err, 1);
    idle(64);
    send(8'h3C, 1'b0, 1'b1, 1'b1);
    idle(16);
    chk("rearm valid", b1.o_uart_rx_valid, 1);
    chk("rearm pdata", b1.o_uart_rx_pdata, 8'h3C);
    pop1();
    chk("rearm single", b1.o_uart_rx_valid, 0);
    clr1();
    sd = 1'b0;
    repeat (20) @(negedge clk);
    idle(150);
    chk("glitch flags", {b1.o_uart_rx_valid, b1.o_uart_rx_parity_err, b1.o_uart_rx_frame_err}, 0);
    send(8'h55, 1'b0, 1'b1, 1'b1);
    idle(16);
    chk("after glitch", {b1.o_uart_rx_valid, b1.o_uart_rx_pdata}, {1'b1, 8'h55});
    pop1();
    for (int i = 0; i < 17; i++) begin
      send(8'(i), 1'b0, 1'b1, 1'b1);
      idle(16);
      if (i == 15) chk("full at 16", {b1.o_uart_fifo_full, b1.o_uart_rx_overrun}, 2'b10);
      if (i == 16) chk("overrun", {b1.o_uart_fifo_full, b1.o_uart_rx_overrun}, 2'b11);
    end
    for (int i = 0; i < 16; i++) begin
      chk("drain", b1.o_uart_rx_pdata, 8'(i));
      pop1();
    end
    chk("drained", {b1.o_uart_rx_valid, b1.o_uart_fifo_full}, 0);
    pop1();
    chk("pop empty", {b1.o_uart_rx_valid, b1.o_uart_rx_pdata}, {1'b0, 8'h00});
    clr1();
    q = {}; mpe = 0; mfe = 0; mov = 0;
    for (int k = 0; k < 24; k++) begin
      logic [7:0] d;
      logic pb, st;
      d = 8'($urandom);
      pb = $urandom_range(0, 3) == 0;
      st = $urandom_range(0, 5) != 0;
      send(d, pb, st, 1'b1);
      idle(16);
      if (!st) mfe = 1;
      else if (pb) mpe = 1;
      else if (q.size() == 16) mov = 1;
      else q.push_back(d);
      chk_model();
      if (q.size() != 0 && $urandom_range(0, 2) == 0) begin
        chk("rnd pdata", b1.o_uart_rx_pdata, q[0]);
        pop1();
        void'(q.pop_front());
      end
      if ($urandom_range(0, 3) == 0) begin
        clr1();
        mpe = 0; mfe = 0; mov = 0;
      end
    end
    while (q.size() != 0) begin
      chk("rnd drain", b1.o_uart_rx_pdata, q[0]);
      pop1();
      void'(q.pop_front());
    end
    chk_model();
    send(8'h77, 1'b0, 1'b1, 1'b1);
    idle(16);
    send(8'h66, 1'b1, 1'b1, 1'b1);
    idle(16);
    cyc = 0; lat1 = -1; lat0 = -1;
    line_bit(1'b0);
    repeat (3) line_bit(1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst outs", {b1.o_uart_rx_valid, b1.o_uart_rx_pdata, b1.o_uart_fifo_full,
        b1.o_uart_rx_parity_err, b1.o_uart_rx_frame_err, b1.o_uart_rx_overrun}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(300);
    chk("midrst no push", b1.o_uart_rx_valid, 0);
    send(8'h12, 1'b0, 1'b1, 1'b1);
    idle(16);
    chk("post rst rx", {b1.o_uart_rx_valid, b1.o_uart_rx_pdata, b1.o_uart_rx_parity_err,
        b1.o_uart_rx_frame_err}, {1'b1, 8'h12, 2'b00});
    pop1();
    chk("post rst one", b1.o_uart_rx_valid, 0);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(20);
    send(8'h12, 1'b0, 1'b1, 1'b0);
    idle(16);
    chk("nopar rx", {b0.o_uart_rx_valid, b0.o_uart_rx_pdata, b0.o_uart_rx_parity_err,
        b0.o_uart_rx_frame_err}, {1'b1, 8'h12, 2'b00});
    chk("nopar latency", lat0 >= 602 && lat0 <= 618, 1);
    b0.i_uart_rx_rd = 1'b1;
    @(negedge clk);
    b0.i_uart_rx_rd = 1'b0;
    chk("nopar pop", b0.o_uart_rx_valid, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
